// File: rtl/morse_key_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : morse_key_decoder_if
// Brief    : Key/tick inputs and letter outputs of the Morse key decoder.
// Revision : 1.0 - initial release
// ============================================================================
interface morse_key_decoder_if #(
    parameter int MAX_SYM = 5,
    parameter int LEN_W   = $clog2(MAX_SYM + 1)
);
    logic               tick;
    logic               key;
    logic               sym_valid;
    logic [MAX_SYM-1:0] sym_code;
    logic [LEN_W-1:0]   sym_len;
    logic               sym_err;
    logic               busy;

    modport master (
        output tick, key,
        input  sym_valid, sym_code, sym_len, sym_err, busy
    );

    modport slave (
        input  tick, key,
        output sym_valid, sym_code, sym_len, sym_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/morse_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : morse_key_decoder
// Brief    : Times key presses against a unit tick, classifies dot/dash and
//            emits each completed letter with a one-cycle valid pulse.
// Revision : 1.0 - initial release
// ============================================================================
module morse_key_decoder #(
    parameter int CNT_W    = 4,
    parameter int DASH_MIN = 2,
    parameter int GAP_MIN  = 3,
    parameter int MAX_SYM  = 5
) (
    input  wire logic          clk,
    input  wire logic          reset,
    morse_key_decoder_if.slave bus
);
    localparam int               LEN_W    = $clog2(MAX_SYM + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] DASH_TH  = CNT_W'(DASH_MIN);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_MIN - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_SYM);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [MAX_SYM-1:0] shreg_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovf_q;
    logic               sym_valid_q;
    logic [MAX_SYM-1:0] sym_code_q;
    logic [LEN_W-1:0]   sym_len_q;
    logic               sym_err_q;
    logic               busy_q;

    // Counter value including this cycle's tick, so a tick coinciding with
    // release still counts toward the press length.
    logic [CNT_W-1:0]   cnt_adv;
    logic               is_dash;
    logic               gap_done;

    assign cnt_adv  = (bus.tick && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;
    assign is_dash  = (cnt_adv >= DASH_TH);
    assign gap_done = bus.tick && (cnt_q == GAP_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            sym_valid_q <= 1'b0;
            sym_code_q  <= '0;
            sym_len_q   <= '0;
            sym_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sym_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.key) begin
                        state_q <= S_PRESS;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_PRESS: begin
                    if (!bus.key) begin
                        if (len_q < LEN_MAX) begin
                            shreg_q <= {shreg_q[MAX_SYM-2:0], is_dash};
                            len_q   <= len_q + 1'b1;
                        end else begin
                            ovf_q   <= 1'b1;
                        end
                        state_q <= S_GAP;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_adv;
                    end
                end
                S_GAP: begin
                    // Letter completion takes priority over a new press.
                    if (gap_done) begin
                        sym_valid_q <= 1'b1;
                        sym_code_q  <= shreg_q;
                        sym_len_q   <= len_q;
                        sym_err_q   <= ovf_q;
                        shreg_q     <= '0;
                        len_q       <= '0;
                        ovf_q       <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= bus.key ? S_PRESS : S_IDLE;
                        busy_q      <= bus.key;
                    end else if (bus.key) begin
                        state_q <= S_PRESS;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_adv;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sym_valid = sym_valid_q;
    assign bus.sym_code  = sym_code_q;
    assign bus.sym_len   = sym_len_q;
    assign bus.sym_err   = sym_err_q;
    assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_morse_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_morse_key_decoder
// Brief    : Scoreboard bench for morse_key_decoder letter decoding.
// Revision : 1.0 - initial release
// ============================================================================
module tb_morse_key_decoder;
    localparam int CNT_W    = 4;
    localparam int DASH_MIN = 2;
    localparam int GAP_MIN  = 3;
    localparam int MAX_SYM  = 5;
    localparam int LEN_W    = 3;

    typedef struct packed {
        logic [MAX_SYM-1:0] code;
        logic [LEN_W-1:0]   len;
        logic               err;
    } letter_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    letter_t            sb_q[$];
    letter_t            exp_l;
    logic [MAX_SYM-1:0] m_code;
    logic [LEN_W-1:0]   m_len;
    logic               m_err;

    morse_key_decoder_if #(.MAX_SYM(MAX_SYM)) bus ();

    morse_key_decoder #(
        .CNT_W    (CNT_W),
        .DASH_MIN (DASH_MIN),
        .GAP_MIN  (GAP_MIN),
        .MAX_SYM  (MAX_SYM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset && bus.sym_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got sym_valid=1 code=%b len=%0d, required no letter",
                         bus.sym_code, bus.sym_len);
            end else begin
                exp_l = sb_q.pop_front();
                if (bus.sym_code !== exp_l.code) begin
                    errors++;
                    $display("FAIL sym_code: got %b required %b", bus.sym_code, exp_l.code);
                end
                checks++;
                if (bus.sym_len !== exp_l.len) begin
                    errors++;
                    $display("FAIL sym_len: got %0d required %0d", bus.sym_len, exp_l.len);
                end
                checks++;
                if (bus.sym_err !== exp_l.err) begin
                    errors++;
                    $display("FAIL sym_err: got %b required %b", bus.sym_err, exp_l.err);
                end
            end
        end
    end

    task automatic cyc(input logic t, input logic k);
        bus.tick = t;
        bus.key  = k;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_code = '0;
        m_len  = '0;
        m_err  = 1'b0;
    endtask

    task automatic model_sym(input logic dash);
        if (m_len < LEN_W'(MAX_SYM)) begin
            m_code = {m_code[MAX_SYM-2:0], dash};
            m_len  = m_len + 1'b1;
        end else begin
            m_err  = 1'b1;
        end
    endtask

    task automatic model_push();
        letter_t e;
        e.code = m_code;
        e.len  = m_len;
        e.err  = m_err;
        sb_q.push_back(e);
        model_clear();
    endtask

    task automatic press(input int n);
        cyc(1'b0, 1'b1);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b1);
            cyc(1'b0, 1'b1);
        end
        cyc(1'b0, 1'b0);
        model_sym(n >= DASH_MIN);
    endtask

    task automatic gap_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0);
            cyc(1'b0, 1'b0);
        end
    endtask

    task automatic end_letter();
        model_push();
        gap_ticks(GAP_MIN);
    endtask

    task automatic drain(input string name);
        int waited;
        waited = 0;
        while (sb_q.size() != 0 && waited < 20) begin
            cyc(1'b0, 1'b0);
            waited++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d letters pending, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        bus.tick = 1'b0;
        bus.key  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.sym_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", bus.sym_valid); end
        checks++;
        if (bus.sym_code !== '0) begin errors++; $display("FAIL rst_code: got %b required 0", bus.sym_code); end
        checks++;
        if (bus.sym_len !== '0) begin errors++; $display("FAIL rst_len: got %0d required 0", bus.sym_len); end
        checks++;
        if (bus.sym_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b required 0", bus.sym_err); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", bus.busy); end
        reset = 1'b1;
        model_clear();
        cyc(1'b0, 1'b0);
    endtask

    task automatic test_single_dot();
        cyc(1'b0, 1'b1);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL dot_busy: got %b required 1", bus.busy); end
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        model_sym(1'b0);
        end_letter();
        drain("single_dot");
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL dot_idle_busy: got %b required 0", bus.busy); end
        repeat (4) cyc(1'b1, 1'b0);
        checks++;
        if (bus.sym_len !== 3'd1) begin errors++; $display("FAIL dot_hold_len: got %0d required 1", bus.sym_len); end
    endtask

    task automatic test_letter_a();
        press(1);
        gap_ticks(1);
        press(3);
        end_letter();
        drain("letter_a");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 6; i++) begin
            press(1);
            if (i < 5) gap_ticks(1);
        end
        end_letter();
        drain("overflow");
    endtask

    task automatic test_saturate();
        press(40);
        end_letter();
        drain("saturate");
    endtask

    task automatic test_reset_mid_press();
        press(1);
        gap_ticks(1);
        press(2);
        gap_ticks(1);
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.sym_code !== '0) begin errors++; $display("FAIL mid_rst_code: got %b required 0", bus.sym_code); end
        checks++;
        if (bus.sym_len !== '0) begin errors++; $display("FAIL mid_rst_len: got %0d required 0", bus.sym_len); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b required 0", bus.busy); end
        model_clear();
        bus.key  = 1'b0;
        bus.tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        gap_ticks(GAP_MIN);
        press(1);
        gap_ticks(1);
        press(2);
        end_letter();
        drain("after_reset");
    endtask

    task automatic test_back_to_back();
        press(1);
        gap_ticks(GAP_MIN - 1);
        cyc(1'b1, 1'b0);
        model_push();
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        model_sym(1'b1);
        end_letter();
        drain("back_to_back");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_dot();
        test_letter_a();
        test_overflow();
        test_saturate();
        test_reset_mid_press();
        test_back_to_back();
        repeat (5) cyc(1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
